// File: rtl/lcd_pkg.sv
// Shared constants, FSM state types and character helpers for the LCD frame writer.
package lcd_pkg;

    localparam logic [7:0] CMD_FUNC_8BIT_2LINE = 8'h38;
    localparam logic [7:0] CMD_DISP_ON         = 8'h0C;
    localparam logic [7:0] CMD_ENTRY_INC       = 8'h06;
    localparam logic [7:0] CMD_CLEAR           = 8'h01;
    localparam logic [7:0] CMD_LINE1           = 8'h80;
    localparam logic [7:0] CMD_LINE2           = 8'hC0;

    localparam logic [4:0] POS_ADDR_TENS  = 5'd4;
    localparam logic [4:0] POS_ADDR_UNITS = 5'd5;
    localparam logic [4:0] POS_MODE       = 5'd14;
    localparam logic [4:0] POS_DIN_HI     = 5'd20;
    localparam logic [4:0] POS_DIN_LO     = 5'd21;
    localparam logic [4:0] POS_DMEM_HI    = 5'd29;
    localparam logic [4:0] POS_DMEM_LO    = 5'd30;
    localparam logic [4:0] LINE1_LAST     = 5'd15;
    localparam logic [4:0] LAST_CHAR      = 5'd31;

    typedef enum logic [2:0] {
        ST_POWERUP,
        ST_INIT,
        ST_LINE,
        ST_FETCH,
        ST_LATCH,
        ST_WRITE,
        ST_NEXT
    } state_t;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_SETUP,
        PH_EN,
        PH_WAIT
    } bus_phase_t;

    typedef struct packed {
        state_t     state;
        bus_phase_t bus_phase;
    } dbg_t;

    function automatic logic [7:0] hex_to_ascii(input logic [3:0] n);
        if (n < 4'd10) return 8'h30 + {4'h0, n};
        else           return 8'h37 + {4'h0, n};
    endfunction

    // Only 0-31 is ever shown, so a compare chain replaces a divider.
    function automatic logic [15:0] dec_digits(input logic [4:0] v);
        logic [4:0] tens;
        logic [4:0] units;
        if (v >= 5'd30) begin
            tens  = 5'd3;
            units = v - 5'd30;
        end else if (v >= 5'd20) begin
            tens  = 5'd2;
            units = v - 5'd20;
        end else if (v >= 5'd10) begin
            tens  = 5'd1;
            units = v - 5'd10;
        end else begin
            tens  = 5'd0;
            units = v;
        end
        return {8'h30 + {3'b000, tens}, 8'h30 + {3'b000, units}};
    endfunction

endpackage

// File: rtl/lcd_frame_writer_if.sv
// Template ROM read port and HD44780 parallel write bus seen by the frame writer.
interface lcd_frame_writer_if;
    logic [4:0] rom_addr;
    logic [7:0] rom_data;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_en;
    logic [7:0] lcd_data;

    modport master (
        output rom_addr,
        input  rom_data,
        output lcd_rs,
        output lcd_rw,
        output lcd_en,
        output lcd_data
    );

    modport slave (
        input  rom_addr,
        output rom_data,
        input  lcd_rs,
        input  lcd_rw,
        input  lcd_en,
        input  lcd_data
    );
endinterface

// File: rtl/lcd_bus_strobe.sv
// One LCD bus write: one setup cycle, EN_CYCLES of lcd_en, then the post-write wait.
module lcd_bus_strobe
    import lcd_pkg::*;
#(
    parameter int unsigned EN_CYCLES  = 25,
    parameter int unsigned CMD_WAIT   = 2500,
    parameter int unsigned CLEAR_WAIT = 100000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       rs_in,
    input  logic [7:0] data_in,
    input  logic       long_wait,
    output logic       lcd_rs,
    output logic       lcd_en,
    output logic [7:0] lcd_data,
    output logic       busy,
    output logic       done,
    output bus_phase_t phase
);

    logic [31:0] cnt;
    logic        long_q;
    logic [31:0] wait_len;

    assign wait_len = long_q ? 32'(CLEAR_WAIT) : 32'(CMD_WAIT);

    // rs/data are held until the next accepted start, so they stay stable through the wait too.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            phase    <= PH_IDLE;
            cnt      <= '0;
            long_q   <= 1'b0;
            lcd_rs   <= 1'b0;
            lcd_en   <= 1'b0;
            lcd_data <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (phase)
                PH_IDLE: begin
                    if (start) begin
                        lcd_rs   <= rs_in;
                        lcd_data <= data_in;
                        long_q   <= long_wait;
                        busy     <= 1'b1;
                        phase    <= PH_SETUP;
                    end
                end
                PH_SETUP: begin
                    lcd_en <= 1'b1;
                    cnt    <= '0;
                    phase  <= PH_EN;
                end
                PH_EN: begin
                    if (cnt == 32'(EN_CYCLES - 1)) begin
                        lcd_en <= 1'b0;
                        cnt    <= '0;
                        phase  <= PH_WAIT;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                PH_WAIT: begin
                    if (cnt == wait_len - 32'd1) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        phase <= PH_IDLE;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                default: phase <= PH_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/lcd_frame_writer.sv
// Initialises a 16x2 HD44780 LCD and streams the ROM template with live values substituted.
module lcd_frame_writer
    import lcd_pkg::*;
#(
    parameter int unsigned EN_CYCLES    = 25,
    parameter int unsigned CMD_WAIT     = 2500,
    parameter int unsigned CLEAR_WAIT   = 100000,
    parameter int unsigned POWERUP_WAIT = 1000000
) (
    input  logic                clock,
    input  logic                reset,
    lcd_frame_writer_if.master  bus,
    input  logic [4:0]          addr_in,
    input  logic                write_mode,
    input  logic [7:0]          data_in,
    input  logic [7:0]          data_mem,
    output logic                frame_done,
    output dbg_t                dbg
);

    // Handshake to the strobe: start is a 1-cycle request taken only while busy is low;
    // done pulses once when the post-write wait ends; pending keeps one write in flight.
    state_t      state;
    logic [31:0] pu_cnt;
    logic [1:0]  init_idx;
    logic [4:0]  char_idx;
    logic        pending;
    logic        start;
    logic        req_rs;
    logic [7:0]  req_data;
    logic        req_long;
    logic [7:0]  char_q;
    logic [4:0]  rom_addr_q;
    logic [4:0]  snap_addr;
    logic        snap_mode;
    logic [7:0]  snap_din;
    logic [7:0]  snap_dmem;
    logic        busy;
    logic        done;
    logic        strobe_rs;
    logic        strobe_en;
    logic [7:0]  strobe_data;
    bus_phase_t  bus_phase;
    logic [7:0]  init_cmd;
    logic [7:0]  sub_char;
    logic [15:0] dec;

    lcd_bus_strobe #(
        .EN_CYCLES  (EN_CYCLES),
        .CMD_WAIT   (CMD_WAIT),
        .CLEAR_WAIT (CLEAR_WAIT)
    ) u_strobe (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .rs_in     (req_rs),
        .data_in   (req_data),
        .long_wait (req_long),
        .lcd_rs    (strobe_rs),
        .lcd_en    (strobe_en),
        .lcd_data  (strobe_data),
        .busy      (busy),
        .done      (done),
        .phase     (bus_phase)
    );

    assign bus.lcd_rs   = strobe_rs;
    assign bus.lcd_en   = strobe_en;
    assign bus.lcd_data = strobe_data;
    assign bus.lcd_rw   = 1'b0;
    assign bus.rom_addr = rom_addr_q;
    assign dbg          = '{state: state, bus_phase: bus_phase};

    always_comb begin
        case (init_idx)
            2'd0:    init_cmd = CMD_FUNC_8BIT_2LINE;
            2'd1:    init_cmd = CMD_DISP_ON;
            2'd2:    init_cmd = CMD_ENTRY_INC;
            default: init_cmd = CMD_CLEAR;
        endcase
    end

    always_comb begin
        dec      = dec_digits(snap_addr);
        sub_char = bus.rom_data;
        case (char_idx)
            POS_ADDR_TENS:  sub_char = dec[15:8];
            POS_ADDR_UNITS: sub_char = dec[7:0];
            POS_MODE:       sub_char = snap_mode ? 8'h57 : 8'h52;
            POS_DIN_HI:     sub_char = hex_to_ascii(snap_din[7:4]);
            POS_DIN_LO:     sub_char = hex_to_ascii(snap_din[3:0]);
            POS_DMEM_HI:    sub_char = hex_to_ascii(snap_dmem[7:4]);
            POS_DMEM_LO:    sub_char = hex_to_ascii(snap_dmem[3:0]);
            default:        sub_char = bus.rom_data;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_POWERUP;
            pu_cnt     <= '0;
            init_idx   <= '0;
            char_idx   <= '0;
            pending    <= 1'b0;
            start      <= 1'b0;
            req_rs     <= 1'b0;
            req_data   <= '0;
            req_long   <= 1'b0;
            char_q     <= '0;
            rom_addr_q <= '0;
            snap_addr  <= '0;
            snap_mode  <= 1'b0;
            snap_din   <= '0;
            snap_dmem  <= '0;
            frame_done <= 1'b0;
        end else begin
            start      <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                ST_POWERUP: begin
                    if (pu_cnt == 32'(POWERUP_WAIT - 1)) begin
                        pu_cnt <= '0;
                        state  <= ST_INIT;
                    end else begin
                        pu_cnt <= pu_cnt + 32'd1;
                    end
                end
                ST_INIT: begin
                    if (!pending && !busy) begin
                        start    <= 1'b1;
                        pending  <= 1'b1;
                        req_rs   <= 1'b0;
                        req_data <= init_cmd;
                        req_long <= (init_cmd == CMD_CLEAR);
                    end else if (done) begin
                        pending <= 1'b0;
                        if (init_idx == 2'd3) begin
                            init_idx <= '0;
                            char_idx <= '0;
                            state    <= ST_LINE;
                        end else begin
                            init_idx <= init_idx + 2'd1;
                        end
                    end
                end
                ST_LINE: begin
                    if (!pending && !busy) begin
                        start    <= 1'b1;
                        pending  <= 1'b1;
                        req_rs   <= 1'b0;
                        req_long <= 1'b0;
                        req_data <= (char_idx == 5'd0) ? CMD_LINE1 : CMD_LINE2;
                        // The whole frame uses the values present when line 1 begins.
                        if (char_idx == 5'd0) begin
                            snap_addr <= addr_in;
                            snap_mode <= write_mode;
                            snap_din  <= data_in;
                            snap_dmem <= data_mem;
                        end
                    end else if (done) begin
                        pending    <= 1'b0;
                        rom_addr_q <= char_idx;
                        state      <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    rom_addr_q <= char_idx;
                    state      <= ST_LATCH;
                end
                ST_LATCH: begin
                    char_q <= sub_char;
                    state  <= ST_WRITE;
                end
                ST_WRITE: begin
                    if (!pending && !busy) begin
                        start    <= 1'b1;
                        pending  <= 1'b1;
                        req_rs   <= 1'b1;
                        req_long <= 1'b0;
                        req_data <= char_q;
                    end else if (done) begin
                        pending <= 1'b0;
                        state   <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    if (char_idx == LAST_CHAR) begin
                        frame_done <= 1'b1;
                        char_idx   <= '0;
                        state      <= ST_LINE;
                    end else if (char_idx == LINE1_LAST) begin
                        char_idx <= char_idx + 5'd1;
                        state    <= ST_LINE;
                    end else begin
                        char_idx   <= char_idx + 5'd1;
                        rom_addr_q <= char_idx + 5'd1;
                        state      <= ST_FETCH;
                    end
                end
                default: state <= ST_POWERUP;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_frame_writer.sv
// Directed bench for lcd_frame_writer: init sequence, frame contents, snapshot, reset abort.
module tb_lcd_frame_writer;
    import lcd_pkg::*;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    lcd_frame_writer_if bus();
    logic [4:0] addr_in;
    logic       write_mode;
    logic [7:0] data_in;
    logic [7:0] data_mem;
    logic       frame_done;
    dbg_t       dbg;

    lcd_frame_writer #(
        .EN_CYCLES    (2),
        .CMD_WAIT     (4),
        .CLEAR_WAIT   (8),
        .POWERUP_WAIT (10)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus),
        .addr_in    (addr_in),
        .write_mode (write_mode),
        .data_in    (data_in),
        .data_mem   (data_mem),
        .frame_done (frame_done),
        .dbg        (dbg)
    );

    // Template ROM model with a 1-cycle registered read.
    logic [7:0] rom [32];
    always @(posedge clock) bus.rom_data <= rom[bus.rom_addr];

    // ---------------- checking / scoreboard ----------------
    int n_vec  = 0;
    int n_fail = 0;
    logic [8:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_cmd(input logic [7:0] c);
        exp_q.push_back({1'b0, c});
    endtask

    task automatic push_text(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back({1'b1, 8'(s[i])});
    endtask

    task automatic push_init();
        push_cmd(8'h38);
        push_cmd(8'h0C);
        push_cmd(8'h06);
        push_cmd(8'h01);
    endtask

    task automatic push_frame(input string l1, input string l2);
        push_cmd(8'h80);
        push_text(l1);
        push_cmd(8'hC0);
        push_text(l2);
    endtask

    // Bus monitor: every rising lcd_en is one write compared against the expected queue.
    int         cyc = 0;
    int         n_writes = 0;
    int         fd_count = 0;
    logic       prev_en = 1'b0;
    logic       prev_rs = 1'b0;
    logic [7:0] prev_data = '0;
    logic [8:0] rise_word = '0;
    int         en_w = 0;
    int         last_fall = 0;
    logic       after_clear = 1'b0;

    always @(negedge clock) begin
        logic [8:0] exp_word;
        cyc++;
        if (reset) begin
            prev_en     = 1'b0;
            en_w        = 0;
            after_clear = 1'b0;
        end else begin
            if (bus.lcd_en && !prev_en) begin
                check("setup_rs", 32'(bus.lcd_rs), 32'(prev_rs));
                check("setup_data", 32'(bus.lcd_data), 32'(prev_data));
                if (after_clear) check("clear_gap_ge8", 32'(cyc - last_fall >= 8), 32'd1);
                after_clear = 1'b0;
                rise_word   = {bus.lcd_rs, bus.lcd_data};
                if (exp_q.size() > 0) exp_word = exp_q.pop_front();
                else                  exp_word = 9'h1FF;
                check($sformatf("write%0d", n_writes), 32'(rise_word), 32'(exp_word));
                check("lcd_rw", 32'(bus.lcd_rw), 32'd0);
                en_w = 1;
                n_writes++;
            end else if (bus.lcd_en && prev_en) begin
                check("hold", 32'({bus.lcd_rs, bus.lcd_data}), 32'(rise_word));
                en_w++;
            end else if (!bus.lcd_en && prev_en) begin
                check("en_width", 32'(en_w), 32'd2);
                last_fall   = cyc;
                after_clear = (rise_word == 9'h001);
            end
            if (frame_done) fd_count++;
            prev_en = bus.lcd_en;
        end
        prev_rs   = bus.lcd_rs;
        prev_data = bus.lcd_data;
    end

    // ---------------- driver tasks ----------------
    task automatic set_inputs(input logic [4:0] a, input logic w, input logic [7:0] d, input logic [7:0] m);
        addr_in    = a;
        write_mode = w;
        data_in    = d;
        data_mem   = m;
    endtask

    task automatic wait_writes(input int n);
        int budget = 0;
        while (n_writes < n && budget < 20000) begin
            @(negedge clock);
            budget++;
        end
        if (n_writes < n) check("timeout_writes", 32'(n_writes), 32'(n));
    endtask

    task automatic check_quiet(input string tag);
        int en_cnt = 0;
        repeat (10) begin
            @(negedge clock);
            if (bus.lcd_en) en_cnt++;
        end
        check(tag, 32'(en_cnt), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check(tag, 32'({bus.rom_addr, bus.lcd_rs, bus.lcd_rw, bus.lcd_en, bus.lcd_data, frame_done}), 32'd0);
        check({tag, "_state"}, 32'(dbg.state), 32'(ST_POWERUP));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        string tmpl;
        int    base;
        int    budget;
        tmpl = "Ain:xx  State:x Din:xx  Dout:xx ";
        for (int i = 0; i < 32; i++) rom[i] = 8'(tmpl[i]);

        set_inputs(5'd27, 1'b1, 8'h3F, 8'hA5);
        push_init();
        push_frame("Ain:27  State:W ", "Din:3F  Dout:A5 ");

        repeat (3) @(negedge clock);
        check_reset_outputs("reset_outputs");
        reset = 1'b0;
        check_quiet("powerup_quiet");

        // Char 31 of frame A is write 37; the next snapshot has not been taken yet.
        wait_writes(38);
        set_inputs(5'd0, 1'b0, 8'h00, 8'hFF);
        push_frame("Ain:00  State:R ", "Din:00  Dout:FF ");
        wait_writes(39);
        check("frame_done_once", 32'(fd_count), 32'd1);

        wait_writes(72);
        set_inputs(5'd31, 1'b1, 8'h11, 8'h5C);
        push_frame("Ain:31  State:W ", "Din:11  Dout:5C ");
        // Write 83 is char 10 of frame C; the change must wait for frame D.
        wait_writes(84);
        data_in = 8'h22;
        push_frame("Ain:31  State:W ", "Din:22  Dout:5C ");

        wait_writes(111);
        check("frame_done_count", 32'(fd_count), 32'd3);

        budget = 0;
        while (!bus.lcd_en && budget < 200) begin
            @(negedge clock);
            budget++;
        end
        check("en_seen_before_reset", 32'(bus.lcd_en), 32'd1);
        @(posedge clock);
        #1 reset = 1'b1;
        #1 check("en_drops_on_reset", 32'(bus.lcd_en), 32'd0);
        check_reset_outputs("midrun_reset_outputs");

        exp_q.delete();
        push_init();
        push_cmd(8'h80);
        repeat (2) @(negedge clock);
        base  = n_writes;
        reset = 1'b0;
        check_quiet("repowerup_quiet");
        wait_writes(base + 5);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
